tc_hdd_arbiter: RTL and testbench
=================================

Name: tc_hdd_arbiter

Overview:
- Shares one TC_Hdd instance (relative-seek, 64-bit word store) between two requesters that issue absolute-address reads and writes.
- Tracks the HDD head position and converts each absolute address into a relative seek, then pulses load or save.
- Round-robin arbitration; one transaction in flight at a time.
- Owns the HDD reset so that the head tracker and the HDD pointer always agree.

Parameters:
- BIT_DEPTH, 256, word count of the attached HDD; addresses >= BIT_DEPTH are rejected.
- DATA_W, 64, data width; must match the HDD word (64).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted on the posedge where valid&&ready.
- req0_write / req1_write  in  1  1=write, 0=read.
- req0_addr / req1_addr  in  64  absolute word address.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse to the owning requester.
- rsp0_err / rsp1_err  out  1  address out of range; valid only with rsp_valid.
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data; valid with rsp_valid on a read, otherwise 0.
- hdd_rst  out  1  active-high reset to the HDD.
- hdd_seek  out  64  relative seek to the HDD.
- hdd_load  out  1  load strobe to the HDD.
- hdd_save  out  1  save strobe to the HDD.
- hdd_in  out  DATA_W  write data to the HDD.
- hdd_out  in  DATA_W  HDD read data, registered inside the HDD.

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE, head=0, last_grant=1 (req0 wins first), hdd_rst=1.
  - All other outputs 0.
  - Mid-transaction reset aborts the transaction; no response is issued.
- hdd_rst timing: stays 1 through the first posedge after rst rises and clears at the second. While hdd_rst=1 both req_ready outputs are 0.
- States: IDLE, SEEK, ACCESS, DONE.
- IDLE arbitration:
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the one != last_grant.
  - req_ready is combinational, only to the grantee, only in IDLE.
  - On accept, latch addr, write, wdata and owner; set last_grant=owner.
- IDLE transitions:
  - addr >= BIT_DEPTH -> DONE with err=1. No seek, load or save is issued.
  - addr == head -> ACCESS (seek skipped).
  - Otherwise -> SEEK.
- SEEK (one cycle):
  - hdd_seek = addr - head, modulo 2^64 (two's complement; wraps exactly as the HDD adds).
  - head <= addr. Next state ACCESS.
- ACCESS (one cycle):
  - hdd_seek=0.
  - Read: hdd_load=1.
  - Write: hdd_save=1, hdd_in=wdata (HDD commits at the negedge, after the pointer reached addr).
  - Next state DONE.
- DONE (one cycle):
  - Owner's rsp_valid=1.
  - rsp_rdata=hdd_out for a read, else 0; rsp_err as latched.
  - Next state IDLE. No new accept in DONE.
- Latency from the accept edge to the rsp_valid cycle:
  - 2 cycles with seek skipped.
  - 3 cycles with seek.
  - 1 cycle on error.
- Throughput: a new accept is possible in the cycle after DONE.
- hdd_seek, hdd_load and hdd_save are 0 in every state not listed above.
- req_valid with no accept carries no obligation; requesters hold their request until ready.

Optional Feature:
- Macro: TC_HDD_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_accesses[31:0] (+1 per DONE without err) and stat_seek_cycles[31:0] (+1 per SEEK cycle).
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package tc_hdd_pkg holds:
  - state enum (IDLE/SEEK/ACCESS/DONE);
  - owner type (1 bit);
  - constant HDD_WORD_W=64.
- One natural sub-module, tc_rr_arb2: 2-way round-robin grant from valid[1:0] and last_grant.

Test Plan:
- Reset release: hdd_rst high through the first posedge after rst rises and low after the second; no ready before that; head=0.
- req0 write addr 5 data 0xDEAD, then req0 read addr 5:
  - write: hdd_seek=5 in SEEK, save in ACCESS;
  - read: SEEK skipped, rsp_rdata=0xDEAD 2 cycles after accept.
- Head at 5, read addr 2: hdd_seek=0xFFFF_FFFF_FFFF_FFFD; the HDD pointer lands on 2; correct data returned.
- req0 and req1 valid every cycle: grants alternate 0,1,0,1; each rsp_valid goes only to its owner.
- Address 256 with BIT_DEPTH=256: rsp_err=1 one cycle after accept; hdd_load, hdd_save and hdd_seek stay 0; head unchanged.
- rst asserted during ACCESS of a write: no rsp_valid; after recovery, head=0 and a read of addr 0 issues no seek.

Source files
------------

// File: rtl/tc_hdd_pkg.sv
// Types and constants shared by the TC_Hdd arbiter and its round-robin grant helper.
package tc_hdd_pkg;
   localparam int HDD_WORD_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEEK   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef logic owner_t;
endpackage

// File: rtl/tc_rr_arb2.sv
// Two-way round-robin grant, purely combinational; a lone requester always wins,
// and on contention the requester that did not win last time is granted.
module tc_rr_arb2
   import tc_hdd_pkg::*;
(
   input  logic [1:0] valid_i,
   input  owner_t     last_grant_i,
   output logic       gnt_vld_o,
   output owner_t     gnt_owner_o
);

   always_comb begin
      gnt_vld_o   = |valid_i;
      gnt_owner_o = 1'b0;
      if (valid_i == 2'b11) begin
         gnt_owner_o = ~last_grant_i;
      end else if (valid_i[1]) begin
         gnt_owner_o = 1'b1;
      end
   end

endmodule

// File: rtl/tc_hdd_arbiter.sv
// Shares one relative-seek TC_Hdd between two absolute-address requesters; optional counters via TC_HDD_ARB_STATS_EN.
// Accept->rsp: 2 cycles (no seek), 3 (seek), 1 (error); one transaction in flight, ready only in IDLE to the grantee.
module tc_hdd_arbiter
   import tc_hdd_pkg::*;
#(
   parameter int BIT_DEPTH = 256,
   parameter int DATA_W    = HDD_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [63:0]       req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [63:0]       req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp0_valid,
   output logic              rsp0_err,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic              rsp1_err,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              hdd_rst,
   output logic [63:0]       hdd_seek,
   output logic              hdd_load,
   output logic              hdd_save,
   output logic [DATA_W-1:0] hdd_in,
   input  logic [DATA_W-1:0] hdd_out
`ifdef TC_HDD_ARB_STATS_EN
   ,
   output logic [31:0]       stat_accesses,
   output logic [31:0]       stat_seek_cycles
`endif
);

   state_t              state_q, state_d;
   logic [63:0]         head_q, head_d;
   owner_t              last_q, last_d;
   owner_t              owner_q, owner_d;
   logic [63:0]         addr_q, addr_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rst_pipe_q;
   logic                hdd_rst_q;

   logic                gnt_vld;
   owner_t              gnt_owner;
   logic [63:0]         sel_addr;
   logic                sel_write;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W-1:0]   rsp_rdata;

   tc_rr_arb2 u_arb (
      .valid_i      ({req1_valid, req0_valid}),
      .last_grant_i (last_q),
      .gnt_vld_o    (gnt_vld),
      .gnt_owner_o  (gnt_owner)
   );

   assign sel_addr  = gnt_owner ? req1_addr  : req0_addr;
   assign sel_write = gnt_owner ? req1_write : req0_write;
   assign sel_wdata = gnt_owner ? req1_wdata : req0_wdata;
   assign rsp_rdata = (!wr_q && !err_q) ? hdd_out : '0;
   assign hdd_rst   = hdd_rst_q;

   // The HDD reset is held for one extra edge so its pointer and head_q both restart at 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_pipe_q <= 1'b1;
         hdd_rst_q  <= 1'b1;
      end else begin
         rst_pipe_q <= 1'b0;
         hdd_rst_q  <= rst_pipe_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      last_d     = last_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      err_d      = err_q;
      wdata_d    = wdata_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp0_err   = 1'b0;
      rsp0_rdata = '0;
      rsp1_valid = 1'b0;
      rsp1_err   = 1'b0;
      rsp1_rdata = '0;
      hdd_seek   = '0;
      hdd_load   = 1'b0;
      hdd_save   = 1'b0;
      hdd_in     = '0;
      case (state_q)
         IDLE: begin
            if (!hdd_rst_q && gnt_vld) begin
               req0_ready = (gnt_owner == 1'b0);
               req1_ready = (gnt_owner == 1'b1);
               owner_d    = gnt_owner;
               last_d     = gnt_owner;
               addr_d     = sel_addr;
               wr_d       = sel_write;
               wdata_d    = sel_wdata;
               err_d      = (sel_addr >= 64'(BIT_DEPTH));
               if (sel_addr >= 64'(BIT_DEPTH)) begin
                  state_d = DONE;
               end else if (sel_addr == head_q) begin
                  state_d = ACCESS;
               end else begin
                  state_d = SEEK;
               end
            end
         end
         SEEK: begin
            // Two's-complement difference wraps the same way the HDD's pointer adder does.
            hdd_seek = addr_q - head_q;
            head_d   = addr_q;
            state_d  = ACCESS;
         end
         ACCESS: begin
            if (wr_q) begin
               hdd_save = 1'b1;
               hdd_in   = wdata_q;
            end else begin
               hdd_load = 1'b1;
            end
            state_d = DONE;
         end
         DONE: begin
            if (owner_q) begin
               rsp1_valid = 1'b1;
               rsp1_err   = err_q;
               rsp1_rdata = rsp_rdata;
            end else begin
               rsp0_valid = 1'b1;
               rsp0_err   = err_q;
               rsp0_rdata = rsp_rdata;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef TC_HDD_ARB_STATS_EN
   logic [31:0] acc_q;
   logic [31:0] seek_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q      <= '0;
         seek_cnt_q <= '0;
      end else begin
         if (state_q == DONE && !err_q && acc_q != '1) begin
            acc_q <= acc_q + 32'd1;
         end
         if (state_q == SEEK && seek_cnt_q != '1) begin
            seek_cnt_q <= seek_cnt_q + 32'd1;
         end
      end
   end

   assign stat_accesses    = acc_q;
   assign stat_seek_cycles = seek_cnt_q;
`endif

endmodule

// File: tb/tb_tc_hdd_arbiter.sv
// Directed bench for tc_hdd_arbiter with a behavioural relative-seek HDD model.
module tb_tc_hdd_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req0_write = 1'b0;
   logic [63:0] req0_addr = '0, req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_write = 1'b0;
   logic [63:0] req1_addr = '0, req1_wdata = '0;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [63:0] rsp0_rdata, rsp1_rdata;
   logic        hdd_rst, hdd_load, hdd_save;
   logic [63:0] hdd_seek, hdd_in;
   logic [63:0] hdd_out;
`ifdef TC_HDD_ARB_STATS_EN
   logic [31:0] stat_accesses, stat_seek_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   tc_hdd_arbiter #(.BIT_DEPTH(256), .DATA_W(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_write (req0_write),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_write (req1_write),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp0_valid (rsp0_valid),
      .rsp0_err   (rsp0_err),
      .rsp0_rdata (rsp0_rdata),
      .rsp1_valid (rsp1_valid),
      .rsp1_err   (rsp1_err),
      .rsp1_rdata (rsp1_rdata),
      .hdd_rst    (hdd_rst),
      .hdd_seek   (hdd_seek),
      .hdd_load   (hdd_load),
      .hdd_save   (hdd_save),
      .hdd_in     (hdd_in),
      .hdd_out    (hdd_out)
`ifdef TC_HDD_ARB_STATS_EN
      ,
      .stat_accesses    (stat_accesses),
      .stat_seek_cycles (stat_seek_cycles)
`endif
   );

   always #5 clk = ~clk;

   // HDD model: pointer moves by the relative seek each edge, load registers the word, save commits at negedge.
   logic [63:0] mem [256];
   logic [63:0] ptr = '0;

   always @(posedge clk) begin
      if (hdd_rst) begin
         ptr     <= '0;
         hdd_out <= '0;
      end else begin
         ptr <= ptr + hdd_seek;
         if (hdd_load) hdd_out <= mem[ptr[7:0]];
      end
   end

   always @(negedge clk) begin
      if (!hdd_rst && hdd_save) mem[ptr[7:0]] = hdd_in;
   end

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (hdd_rst !== 1'b1) begin n_fail++; $display("FAIL rst_hdd_rst: got %b exp 1", hdd_rst); end
      n_checks++;
      if ({hdd_seek, hdd_load, hdd_save, hdd_in, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== '0) begin
         n_fail++; $display("FAIL rst_outputs: seek %h load %b save %b in %h rv0 %b rv1 %b rdy %b%b exp all 0",
                            hdd_seek, hdd_load, hdd_save, hdd_in, rsp0_valid, rsp1_valid, req0_ready, req1_ready);
      end
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (hdd_rst !== 1'b1) begin n_fail++; $display("FAIL rel_edge1_hdd_rst: got %b exp 1", hdd_rst); end
      n_checks++;
      if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rel_edge1_ready: got %b exp 0", req0_ready); end
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (hdd_rst !== 1'b0) begin n_fail++; $display("FAIL rel_edge2_hdd_rst: got %b exp 0", hdd_rst); end
      n_checks++;
      if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rel_edge2_ready: got %b exp 1", req0_ready); end
      req0_valid = 1'b0;
   endtask

   task automatic test_write_read;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 64'd5; req0_wdata = 64'hDEAD;
      @(negedge clk);
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL wr_ready: got %b%b exp 10", req0_ready, req1_ready); end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hdd_seek !== 64'd5 || hdd_save !== 1'b0) begin n_fail++; $display("FAIL wr_seek: seek %h save %b exp 5/0", hdd_seek, hdd_save); end
      @(negedge clk);
      n_checks++;
      if (hdd_save !== 1'b1 || hdd_in !== 64'hDEAD || hdd_seek !== 64'd0) begin
         n_fail++; $display("FAIL wr_access: save %b in %h seek %h exp 1/dead/0", hdd_save, hdd_in, hdd_seek);
      end
      @(negedge clk);
      n_checks++;
      if (rsp0_valid !== 1'b1 || rsp0_err !== 1'b0 || rsp0_rdata !== 64'd0 || rsp1_valid !== 1'b0) begin
         n_fail++; $display("FAIL wr_rsp: v0 %b err %b rd %h v1 %b exp 1/0/0/0", rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid);
      end
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd5;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hdd_load !== 1'b1 || hdd_seek !== 64'd0) begin n_fail++; $display("FAIL rd_noseek: load %b seek %h exp 1/0", hdd_load, hdd_seek); end
      @(negedge clk);
      n_checks++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== 64'hDEAD) begin
         n_fail++; $display("FAIL rd_data: v %b rd %h exp 1/dead", rsp0_valid, rsp0_rdata);
      end
   endtask

   task automatic test_neg_seek;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd2;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hdd_seek !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL neg_seek: got %h exp fffffffffffffffd", hdd_seek); end
      @(negedge clk);
      n_checks++;
      if (ptr !== 64'd2 || hdd_load !== 1'b1) begin n_fail++; $display("FAIL neg_ptr: ptr %h load %b exp 2/1", ptr, hdd_load); end
      @(negedge clk);
      n_checks++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== 64'h1002) begin
         n_fail++; $display("FAIL neg_data: v %b rd %h exp 1/1002", rsp0_valid, rsp0_rdata);
      end
   endtask

   task automatic test_addr_err;
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 64'd256; req1_wdata = 64'h5555;
      @(negedge clk);
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL err_ready: got %b%b exp 01", req0_ready, req1_ready); end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp0_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_rsp: v1 %b err %b v0 %b exp 1/1/0", rsp1_valid, rsp1_err, rsp0_valid);
      end
      n_checks++;
      if (hdd_seek !== 64'd0 || hdd_load !== 1'b0 || hdd_save !== 1'b0) begin
         n_fail++; $display("FAIL err_hdd_quiet: seek %h load %b save %b exp 0/0/0", hdd_seek, hdd_load, hdd_save);
      end
      // Head must still be 2: a read of 2 goes straight to ACCESS.
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd2;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hdd_load !== 1'b1 || hdd_seek !== 64'd0) begin n_fail++; $display("FAIL err_head: load %b seek %h exp 1/0", hdd_load, hdd_seek); end
      @(negedge clk);
      n_checks++;
      if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b0 || rsp1_rdata !== 64'h1002) begin
         n_fail++; $display("FAIL err_followup: v %b err %b rd %h exp 1/0/1002", rsp1_valid, rsp1_err, rsp1_rdata);
      end
   endtask

   task automatic test_back_to_back;
      int got;
      logic exp_owner;
      got = 0;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd2;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 64'd3;
      for (int c = 0; c < 60 && got < 4; c++) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) begin
            exp_owner = got[0];
            n_checks++;
            if (rsp0_valid === rsp1_valid || rsp1_valid !== exp_owner) begin
               n_fail++; $display("FAIL rr_owner%0d: v0 %b v1 %b exp owner %0d", got, rsp0_valid, rsp1_valid, exp_owner);
            end
            n_checks++;
            if ((exp_owner ? rsp1_rdata : rsp0_rdata) !== (exp_owner ? 64'h1003 : 64'h1002)) begin
               n_fail++; $display("FAIL rr_data%0d: rd0 %h rd1 %h exp %h", got, rsp0_rdata, rsp1_rdata,
                                  exp_owner ? 64'h1003 : 64'h1002);
            end
            got++;
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      n_checks++;
      if (got != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d responses exp 4", got); end
   endtask

   task automatic test_mid_reset;
      int stray;
      stray = 0;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 64'd7; req0_wdata = 64'hBEEF;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (hdd_save !== 1'b1) begin n_fail++; $display("FAIL mr_in_access: save %b exp 1", hdd_save); end
      rst = 1'b0;
      #1;
      n_checks++;
      if (hdd_rst !== 1'b1 || hdd_save !== 1'b0 || rsp0_valid !== 1'b0) begin
         n_fail++; $display("FAIL mr_abort: hdd_rst %b save %b v0 %b exp 1/0/0", hdd_rst, hdd_save, rsp0_valid);
      end
      repeat (3) begin
         @(negedge clk);
         if (rsp0_valid || rsp1_valid) stray++;
      end
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         if (rsp0_valid || rsp1_valid) stray++;
      end
      n_checks++;
      if (stray != 0) begin n_fail++; $display("FAIL mr_no_rsp: got %0d stray responses exp 0", stray); end
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hdd_load !== 1'b1 || hdd_seek !== 64'd0) begin n_fail++; $display("FAIL mr_head0: load %b seek %h exp 1/0", hdd_load, hdd_seek); end
      @(negedge clk);
      n_checks++;
      if (rsp0_valid !== 1'b1 || rsp0_rdata !== 64'h1000) begin
         n_fail++; $display("FAIL mr_data: v %b rd %h exp 1/1000", rsp0_valid, rsp0_rdata);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 64'h1000 + 64'(i);
      test_reset();
      test_write_read();
      test_neg_seek();
      test_addr_err();
      test_back_to_back();
      test_mid_reset();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
